des_round_sequencer: RTL and testbench

- Control FSM for the iterative DES core: one round datapath reused for 16 rounds.
- Accepts a block/key start request via valid/ready handshake.
- Sequences the data path: IP load, 16 rounds, FP capture.
- Sequences the key schedule: PC-1 load, per-round C/D rotation amount and direction for encrypt/decrypt, PC-2 round-key use.
- Holds the result-valid signal until downstream accepts it.
- Drives only control signals. The permutation tables and round logic are instantiated in the sibling datapath.

---
 rtl/des_round_sequencer.sv | 124 ++++++++++++
 tb/tb_des_round_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: control FSM for an iterative DES core; drives IP/PC-1 loads,
// per-round commit and key-rotation controls, FP capture and the result handshake.
module des_round_sequencer #(
    parameter int ROUND_CYCLES = 1,
    parameter int ROUNDS       = 16
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       inValid,
    input  logic       inDecrypt,
    output logic       inReady,
    input  logic       abort,
    output logic       dpLoad,
    output logic       keyLoad,
    output logic       roundEn,
    output logic       keyShiftEn,
    output logic [1:0] keyShiftAmt,
    output logic       keyShiftDir,
    output logic [3:0] roundIdx,
    output logic       fpLoad,
    output logic       outValid,
    input  logic       outReady,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    localparam logic [1:0] RCM  = 2'(ROUND_CYCLES - 1);
    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t     state;
    logic [1:0] sub;
    logic       mode;

    // Decrypt walks the encrypt schedule backwards, rotating right by S[16-r].
    function automatic logic [1:0] shift_amt(input logic [3:0] r, input logic dec);
        logic [3:0] k;
        k = dec ? 4'(5'd16 - {1'b0, r}) : r;
        return (dec && r == 4'd0) ? 2'd0 :
               (k == 4'd0 || k == 4'd1 || k == 4'd8 || k == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    assign inReady = (state == IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            sub         <= '0;
            mode        <= 1'b0;
            roundIdx    <= '0;
            dpLoad      <= 1'b0;
            keyLoad     <= 1'b0;
            roundEn     <= 1'b0;
            keyShiftEn  <= 1'b0;
            keyShiftAmt <= '0;
            keyShiftDir <= 1'b0;
            fpLoad      <= 1'b0;
            outValid    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dpLoad     <= 1'b0;
            keyLoad    <= 1'b0;
            roundEn    <= 1'b0;
            keyShiftEn <= 1'b0;
            fpLoad     <= 1'b0;
            if (abort && state != IDLE) begin
                state       <= IDLE;
                outValid    <= 1'b0;
                busy        <= 1'b0;
                keyShiftAmt <= '0;
                keyShiftDir <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (inValid) begin
                        mode     <= inDecrypt;
                        state    <= LOAD;
                        dpLoad   <= 1'b1;
                        keyLoad  <= 1'b1;
                        busy     <= 1'b1;
                        roundIdx <= '0;
                        sub      <= '0;
                    end
                    LOAD: begin
                        state       <= ROUND;
                        roundIdx    <= '0;
                        sub         <= '0;
                        keyShiftAmt <= shift_amt(4'd0, mode);
                        keyShiftDir <= mode;
                        roundEn     <= (RCM == 2'd0);
                        keyShiftEn  <= (RCM == 2'd0);
                    end
                    ROUND: begin
                        // Outputs are registered, so strobes are set one edge ahead of the commit cycle.
                        if (sub != RCM) begin
                            sub        <= sub + 2'd1;
                            roundEn    <= (sub + 2'd1 == RCM);
                            keyShiftEn <= (sub + 2'd1 == RCM);
                        end else if (roundIdx == LAST) begin
                            state       <= FINAL;
                            fpLoad      <= 1'b1;
                            keyShiftAmt <= '0;
                            keyShiftDir <= 1'b0;
                        end else begin
                            roundIdx    <= roundIdx + 4'd1;
                            sub         <= '0;
                            keyShiftAmt <= shift_amt(roundIdx + 4'd1, mode);
                            roundEn     <= (RCM == 2'd0);
                            keyShiftEn  <= (RCM == 2'd0);
                        end
                    end
                    FINAL: begin
                        state    <= DONE;
                        outValid <= 1'b1;
                    end
                    DONE: if (outReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                        busy     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: directed checks of handshake timing, round/key schedule,
// backpressure, abort, async reset and a ROUND_CYCLES=3 build.
module tb_des_round_sequencer;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic in_valid = 1'b0, in_decrypt = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic in_ready, dp_load, key_load, round_en, key_shift_en, key_shift_dir, fp_load, out_valid, busy;
    logic [1:0] key_shift_amt;
    logic [3:0] round_idx;
    logic v3 = 1'b0;
    logic r3_ready, r3_dp, r3_key, r3_round, r3_kse, r3_dir, r3_fp, r3_ov, r3_busy;
    logic [1:0] r3_amt;
    logic [3:0] r3_idx;
    int checks = 0, failures = 0;
    int enc_tbl[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_tbl[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    always #5 clk = ~clk;

    des_round_sequencer #(.ROUND_CYCLES(1), .ROUNDS(16)) dut (
        .clk(clk), .rstN(rstN), .inValid(in_valid), .inDecrypt(in_decrypt), .inReady(in_ready),
        .abort(abort), .dpLoad(dp_load), .keyLoad(key_load), .roundEn(round_en),
        .keyShiftEn(key_shift_en), .keyShiftAmt(key_shift_amt), .keyShiftDir(key_shift_dir),
        .roundIdx(round_idx), .fpLoad(fp_load), .outValid(out_valid), .outReady(out_ready), .busy(busy)
    );

    des_round_sequencer #(.ROUND_CYCLES(3), .ROUNDS(16)) dut3 (
        .clk(clk), .rstN(rstN), .inValid(v3), .inDecrypt(1'b0), .inReady(r3_ready),
        .abort(1'b0), .dpLoad(r3_dp), .keyLoad(r3_key), .roundEn(r3_round),
        .keyShiftEn(r3_kse), .keyShiftAmt(r3_amt), .keyShiftDir(r3_dir),
        .roundIdx(r3_idx), .fpLoad(r3_fp), .outValid(r3_ov), .outReady(1'b1), .busy(r3_busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_outs"}, {dp_load, key_load, round_en, key_shift_en, fp_load, out_valid, busy}, 0);
        chk({tag, "_amtdir"}, {key_shift_amt, key_shift_dir}, 0);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    // Full block from accept to handshake; hold = cycles of outReady low after outValid.
    task automatic run(input logic dec, input int hold);
        int sum = 0;
        @(negedge clk);
        in_valid = 1'b1; in_decrypt = dec;
        chk("acc_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_decrypt = ~dec;
        chk("load", {dp_load, key_load, busy, in_ready, round_en}, 5'b11100);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            chk($sformatf("rnd%0d_en", r), {round_en, key_shift_en, dp_load, fp_load}, 4'b1100);
            chk($sformatf("rnd%0d_idx", r), round_idx, r);
            chk($sformatf("rnd%0d_amt", r), key_shift_amt, dec ? dec_tbl[r] : enc_tbl[r]);
            chk($sformatf("rnd%0d_dir", r), key_shift_dir, dec);
            sum += int'(key_shift_amt);
        end
        chk("shift_sum", sum, dec ? 27 : 28);
        @(negedge clk);
        chk("final", {fp_load, round_en, out_valid}, 3'b100);
        @(negedge clk);
        chk("out_valid", {out_valid, fp_load, in_ready, busy}, 4'b1001);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", {out_valid, in_ready, dp_load}, 3'b100);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        #2;
        check_idle("reset");
        @(negedge clk);
        rstN = 1'b1;
        run(1'b0, 0);
        run(1'b1, 10);
        // abort at round 7 (a commit cycle) must win and return to IDLE
        @(negedge clk);
        in_valid = 1'b1; in_decrypt = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_at_idx", round_idx, 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort");
        begin
            int seen = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                seen += int'(fp_load) + int'(out_valid) + int'(busy);
            end
            chk("abort_quiet", seen, 0);
        end
        // abort in IDLE is ignored and the request is still taken
        abort = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idle_acc", {dp_load, busy}, 2'b11);
        repeat (20) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("abort_idle_done", {in_ready, busy}, 2'b10);
        run(1'b0, 0);
        // async reset mid-round, off the clock edge
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {busy, round_en}, 2'b11);
        #2 rstN = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        rstN = 1'b1;
        run(1'b0, 0);
        // ROUND_CYCLES = 3 build
        begin
            int pulses = 0, first_ov = -1;
            @(negedge clk);
            v3 = 1'b1;
            for (int c = 1; c <= 55; c++) begin
                @(negedge clk);
                v3 = 1'b0;
                pulses += int'(r3_round);
                if (r3_ov && first_ov < 0) first_ov = c;
                if (c >= 2 && c <= 49) begin
                    chk($sformatf("rc3_c%0d_amt", c), r3_amt, enc_tbl[(c - 2) / 3]);
                    chk($sformatf("rc3_c%0d_en", c), {r3_round, r3_kse}, ((c - 2) % 3 == 2) ? 3 : 0);
                end
            end
            chk("rc3_pulses", pulses, 16);
            chk("rc3_ov_cycle", first_ov, 51);
            chk("rc3_idle", {r3_ready, r3_busy}, 2'b10);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
